lif_membrane_integrator: RTL and testbench

LIF_MEMBRANE_INTEGRATOR -- requirements
Module: lif_membrane_integrator

---
 rtl/lif_membrane_integrator_pkg.sv | 21 ++
 rtl/lif_membrane_integrator_threshold_element.sv | 12 +
 rtl/lif_membrane_integrator.sv | 117 +++++++++++
 tb/tb_lif_membrane_integrator.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/lif_membrane_integrator_pkg.sv
// Shared types and helpers for the leaky integrate-and-fire membrane integrator.
// Holds the FSM state encoding and the signed saturation limits for a given word width.
package lif_membrane_integrator_pkg;

  typedef enum logic [0:0] {
    StIntegrate  = 1'b0,
    StRefractory = 1'b1
  } lif_state_e;

  localparam int unsigned DefaultDataWidth = 16;

  // Limits are returned 64-bit wide; callers truncate to their own DATA_WIDTH.
  function automatic logic signed [63:0] sat_max(input int unsigned width);
    return (64'sd1 <<< (width - 1)) - 64'sd1;
  endfunction

  function automatic logic signed [63:0] sat_min(input int unsigned width);
    return -(64'sd1 <<< (width - 1));
  endfunction

endpackage

// File: rtl/lif_membrane_integrator_threshold_element.sv
// Combinational signed comparator: fires when the value reaches or exceeds the threshold.
module threshold_element #(
  parameter int unsigned DATA_WIDTH = 16
) (
  input  logic signed [DATA_WIDTH-1:0] i_value,
  input  logic signed [DATA_WIDTH-1:0] i_threshold,
  output logic                         o_fire
);

  assign o_fire = (i_value >= i_threshold);

endmodule

// File: rtl/lif_membrane_integrator.sv
// LIF neuron membrane: saturating integration of accepted currents, leak and
// threshold test on tick, one-cycle spike and a tick-counted refractory period.
module lif_membrane_integrator
  import lif_membrane_integrator_pkg::*;
#(
  parameter int unsigned DATA_WIDTH       = DefaultDataWidth,
  parameter int unsigned LEAK_SHIFT       = 4,
  parameter int unsigned REFRACTORY_TICKS = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic signed [DATA_WIDTH-1:0] in_current,
  input  logic                         tick,
  input  logic signed [DATA_WIDTH-1:0] threshold,
  input  logic signed [DATA_WIDTH-1:0] reset_potential,
  output logic signed [DATA_WIDTH-1:0] membrane_potential,
  output logic                         spike,
  output logic                         refractory
);

  localparam int unsigned CntWidth =
      (REFRACTORY_TICKS > 0) ? $clog2(REFRACTORY_TICKS + 1) : 1;
  localparam logic signed [DATA_WIDTH-1:0] SatMax = DATA_WIDTH'(sat_max(DATA_WIDTH));
  localparam logic signed [DATA_WIDTH-1:0] SatMin = DATA_WIDTH'(sat_min(DATA_WIDTH));
  localparam logic [CntWidth-1:0] CntLoad = CntWidth'(REFRACTORY_TICKS);
  localparam logic [CntWidth-1:0] CntOne  = CntWidth'(1);

  lif_state_e r_state, w_state_d;
  logic signed [DATA_WIDTH-1:0] r_v, w_v_d;
  logic [CntWidth-1:0]          r_cnt, w_cnt_d;
  logic                         r_spike, w_spike_d;

  logic                         w_accept;
  logic signed [DATA_WIDTH:0]   w_sum;
  logic signed [DATA_WIDTH-1:0] w_sum_sat;
  logic signed [DATA_WIDTH-1:0] w_leaked;
  logic                         w_fire;

  assign in_ready = !tick;
  assign w_accept = in_valid && in_ready;

  // One guard bit: overflow shows as a disagreement between the top two sum bits.
  assign w_sum = {r_v[DATA_WIDTH-1], r_v} + {in_current[DATA_WIDTH-1], in_current};
  always_comb begin
    w_sum_sat = w_sum[DATA_WIDTH-1:0];
    if (w_sum[DATA_WIDTH] != w_sum[DATA_WIDTH-1]) begin
      w_sum_sat = w_sum[DATA_WIDTH] ? SatMin : SatMax;
    end
  end

  assign w_leaked = r_v - (r_v >>> LEAK_SHIFT);

  threshold_element #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_threshold (
    .i_value     (w_leaked),
    .i_threshold (threshold),
    .o_fire      (w_fire)
  );

  always_comb begin
    w_state_d = r_state;
    w_v_d     = r_v;
    w_cnt_d   = r_cnt;
    w_spike_d = 1'b0;
    unique case (r_state)
      StIntegrate: begin
        if (tick) begin
          if (w_fire) begin
            w_v_d     = reset_potential;
            w_spike_d = 1'b1;
            if (REFRACTORY_TICKS != 0) begin
              w_cnt_d   = CntLoad;
              w_state_d = StRefractory;
            end
          end else begin
            w_v_d = w_leaked;
          end
        end else if (w_accept) begin
          w_v_d = w_sum_sat;
        end
      end
      StRefractory: begin
        // Inputs are still accepted here but discarded; only ticks advance state.
        if (tick) begin
          w_cnt_d = r_cnt - CntOne;
          if (r_cnt <= CntOne) begin
            w_cnt_d   = '0;
            w_state_d = StIntegrate;
          end
        end
      end
      default: w_state_d = StIntegrate;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIntegrate;
      r_v     <= '0;
      r_cnt   <= '0;
      r_spike <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_v     <= w_v_d;
      r_cnt   <= w_cnt_d;
      r_spike <= w_spike_d;
    end
  end

  assign membrane_potential = r_v;
  assign spike              = r_spike;
  assign refractory         = (r_state == StRefractory);

endmodule

// File: tb/tb_lif_membrane_integrator.sv
// Directed self-checking bench for lif_membrane_integrator (16-bit, shift 4, 2 refractory ticks).
module tb_lif_membrane_integrator;

  logic               clk;
  logic               rst_n;
  logic               in_valid;
  logic               in_ready;
  logic signed [15:0] in_current;
  logic               tick;
  logic signed [15:0] threshold;
  logic signed [15:0] reset_potential;
  logic signed [15:0] membrane_potential;
  logic               spike;
  logic               refractory;

  int n_tests;
  int n_fail;

  lif_membrane_integrator #(
    .DATA_WIDTH       (16),
    .LEAK_SHIFT       (4),
    .REFRACTORY_TICKS (2)
  ) u_dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .in_valid           (in_valid),
    .in_ready           (in_ready),
    .in_current         (in_current),
    .tick               (tick),
    .threshold          (threshold),
    .reset_potential    (reset_potential),
    .membrane_potential (membrane_potential),
    .spike              (spike),
    .refractory         (refractory)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and land 1 time unit past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input logic signed [15:0] cur);
    in_valid   = 1'b1;
    in_current = cur;
    tick       = 1'b0;
    step();
    in_valid   = 1'b0;
    in_current = '0;
  endtask

  task automatic do_tick(input logic signed [15:0] thr);
    tick      = 1'b1;
    threshold = thr;
    step();
    tick      = 1'b0;
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    #1;
  endtask

  initial begin
    n_tests         = 0;
    n_fail          = 0;
    rst_n           = 1'b0;
    in_valid        = 1'b0;
    in_current      = '0;
    tick            = 1'b0;
    threshold       = 16'sd1000;
    reset_potential = '0;

    // Reset state
    #12;
    check_eq("rst_v", int'(membrane_potential), 0);
    check_eq("rst_spike", int'(spike), 0);
    check_eq("rst_refr", int'(refractory), 0);
    check_eq("rst_ready", int'(in_ready), 1);
    @(negedge clk);
    rst_n = 1'b1;

    // Integrate then leak without firing
    accept(16'sd100);
    accept(16'sd100);
    accept(16'sd100);
    check_eq("int_300", int'(membrane_potential), 300);
    do_tick(16'sd1000);
    check_eq("leak_282", int'(membrane_potential), 282);
    check_eq("leak_nospike", int'(spike), 0);
    check_eq("leak_norefr", int'(refractory), 0);
    step();
    check_eq("idle_hold", int'(membrane_potential), 282);

    // Fire: 1200 leaks to 1125 >= 1000
    pulse_reset();
    accept(16'sd600);
    accept(16'sd600);
    check_eq("int_1200", int'(membrane_potential), 1200);
    do_tick(16'sd1000);
    check_eq("fire_spike", int'(spike), 1);
    check_eq("fire_v", int'(membrane_potential), 0);
    check_eq("fire_refr", int'(refractory), 1);
    step();
    check_eq("spike_1cyc", int'(spike), 0);
    check_eq("refr_held", int'(refractory), 1);

    // Refractory discards input, ends after two ticks
    check_eq("refr_ready", int'(in_ready), 1);
    accept(16'sd500);
    check_eq("refr_discard", int'(membrane_potential), 0);
    do_tick(16'sd1000);
    check_eq("refr_tick1", int'(refractory), 1);
    check_eq("refr_tick1_v", int'(membrane_potential), 0);
    do_tick(16'sd1000);
    check_eq("refr_tick2", int'(refractory), 0);
    check_eq("refr_exit_v", int'(membrane_potential), 0);
    accept(16'sd500);
    check_eq("post_refr_500", int'(membrane_potential), 500);

    // Saturation
    pulse_reset();
    accept(16'sd32000);
    check_eq("int_32000", int'(membrane_potential), 32000);
    accept(16'sd1000);
    check_eq("sat_pos", int'(membrane_potential), 32767);
    pulse_reset();
    accept(-16'sd32000);
    accept(-16'sd1000);
    check_eq("sat_neg", int'(membrane_potential), -32768);
    do_tick(16'sd32767);
    check_eq("leak_neg", int'(membrane_potential), -30720);
    check_eq("leak_neg_nospike", int'(spike), 0);

    // Equality fires: 1000 leaks to 938
    pulse_reset();
    accept(16'sd1000);
    do_tick(16'sd938);
    check_eq("eq_fire", int'(spike), 1);
    check_eq("eq_refr", int'(refractory), 1);

    // Async reset during refractory takes effect before any clock edge
    rst_n = 1'b0;
    #2;
    check_eq("arst_v", int'(membrane_potential), 0);
    check_eq("arst_refr", int'(refractory), 0);
    check_eq("arst_spike", int'(spike), 0);
    rst_n = 1'b1;
    #1;
    check_eq("arst_ready", int'(in_ready), 1);

    // tick with in_valid: input held off, then taken once tick drops
    step();
    accept(16'sd100);
    in_valid   = 1'b1;
    in_current = 16'sd500;
    tick       = 1'b1;
    threshold  = 16'sd1000;
    #1;
    check_eq("tick_ready0", int'(in_ready), 0);
    step();
    check_eq("tick_no_input", int'(membrane_potential), 94);
    tick = 1'b0;
    #1;
    check_eq("tick_ready1", int'(in_ready), 1);
    step();
    in_valid = 1'b0;
    check_eq("held_input", int'(membrane_potential), 594);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
